// File: rtl/agc_uplink_pkg.sv
// Shared types and helpers for the AGC uplink transmitter.
package agc_uplink_pkg;

  localparam int unsigned WORD_W   = 15;
  localparam int unsigned KEY_W    = 5;
  localparam int unsigned BITCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // DSKY-style redundant keycode frame: keycode, its complement, keycode again.
  function automatic logic [WORD_W-1:0] expand_keycode(input logic [KEY_W-1:0] c);
    return {c, ~c, c};
  endfunction

endpackage

// File: rtl/uplink_pulse_timer.sv
// Loadable down-counter with a terminal-count flag; shared by the pulse and gap phases.
// Ports:
//   clk, rst     clock, async active-high reset
//   load         load load_val this cycle (takes priority over counting)
//   load_val     new count
//   tc_c         combinational: counter is in its last cycle (count == 1)
module uplink_pulse_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt;

  // Counts down to zero and parks there until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/uplink_tx.sv
// Serial uplink transmitter: sends a 15-bit word MSB first as pulses on
// upl1 (one bits) or upl0 (zero bits), each followed by a low gap.
// Build option: UPLINK_KEYCODE_EN sends {c,~c,c} built from in_data[4:0].
// Ports:
//   clk, rst   clock, async active-high reset
//   in_data    word to send (sampled only at acceptance)
//   in_valid   word offered; in_ready  idle, can accept
//   upl0/upl1  registered pulse lines for 0/1 bits
//   busy       frame in progress; done  one-cycle end-of-frame strobe
module uplink_tx
  import agc_uplink_pkg::*;
#(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              upl0,
  output logic              upl1,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   shreg;
  logic [BITCNT_W-1:0] bit_cnt;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_tc;
  logic                accept;
  logic                last_bit;
  logic [WORD_W-1:0]   frame;
  logic                upl0_d, upl1_d, busy_d, ready_d, done_d;

  assign accept   = in_valid & in_ready;
  assign last_bit = (bit_cnt == BITCNT_W'(1));

`ifdef UPLINK_KEYCODE_EN
  assign frame = expand_keycode(in_data[KEY_W-1:0]);
`else
  assign frame = in_data;
`endif

  uplink_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc_c     (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and timer reload on every phase change.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = CNT_W'(PULSE_W);
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PULSE;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(PULSE_W);
        end
      end
      PULSE: begin
        if (tmr_tc) begin
          state_nxt = GAP;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(GAP_W);
        end
      end
      GAP: begin
        if (tmr_tc) begin
          if (last_bit) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = PULSE;
            tmr_load  = 1'b1;
            tmr_val   = CNT_W'(PULSE_W);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; pulse lines lag the PULSE state by one cycle.
  always_comb begin
    upl0_d  = 1'b0;
    upl1_d  = 1'b0;
    busy_d  = (state_nxt != IDLE);
    ready_d = (state_nxt == IDLE);
    done_d  = 1'b0;
    if (state == PULSE) begin
      upl1_d = shreg[WORD_W-1];
      upl0_d = ~shreg[WORD_W-1];
    end
    if ((state == GAP) && tmr_tc && last_bit) done_d = 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upl0     <= 1'b0;
      upl1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      upl0     <= upl0_d;
      upl1     <= upl1_d;
      busy     <= busy_d;
      done     <= done_d;
      in_ready <= ready_d;
    end
  end

  // Shift register and bit counter: load at accept, advance at the end of each gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if ((state == IDLE) && accept) begin
      shreg   <= frame;
      bit_cnt <= BITCNT_W'(WORD_W);
    end else if ((state == GAP) && tmr_tc) begin
      shreg   <= {shreg[WORD_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - BITCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uplink_tx.sv
// Scoreboard bench for uplink_tx: the driver queues expected pulses and done
// cycles at each accept; a negedge monitor pops and compares them.
module tb_uplink_tx;

  localparam int PW = 4;
  localparam int GW = 12;
  localparam int BP = PW + GW;
  localparam int NB = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] in_data;
  logic        in_valid;
  logic        in_ready, upl0, upl1, busy, done;

  uplink_tx #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .upl0     (upl0),
    .upl1     (upl1),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   cyc;
    logic bit_v;
  } pulse_t;

  pulse_t pq[$];
  int     dq[$];
  logic   in_pulse = 1'b0;
  int     width    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] model_frame(input logic [14:0] w);
`ifdef UPLINK_KEYCODE_EN
    return {w[4:0], ~w[4:0], w[4:0]};
`else
    return w;
`endif
  endfunction

  // Offer a word (called at a negedge); queue its expected pulses and done cycle.
  task automatic send(input logic [14:0] w, output int acc);
    logic [14:0] f;
    int guard;
    in_valid = 1'b1;
    in_data  = w;
    guard    = 0;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready never rose (cycle %0d)", cyc);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    f = model_frame(w);
    for (int i = 0; i < NB; i++) pq.push_back('{acc + 1 + BP * i, f[14 - i]});
    dq.push_back(acc + NB * BP);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~w;
    @(negedge clk);
    chk("ready_low_after_accept", int'(in_ready), 0);
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((pq.size() != 0 || dq.size() != 0 || in_pulse || !in_ready) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("frame_completes", int'(guard < 1000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pulse start/bit/width, line exclusivity, done timing.
  always @(negedge clk) begin
    if (rst) begin
      in_pulse = 1'b0;
      width    = 0;
    end else begin
      pulse_t p;
      chk("lines_exclusive", int'(upl0 & upl1), 0);
      if ((upl0 | upl1) && !in_pulse) begin
        in_pulse = 1'b1;
        width    = 1;
        if (pq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: upl1=%0d upl0=%0d with nothing expected (cycle %0d)", upl1, upl0, cyc);
        end else begin
          p = pq.pop_front();
          chk("pulse_start", cyc, p.cyc);
          chk("pulse_bit", int'(upl1), int'(p.bit_v));
        end
      end else if (in_pulse) begin
        if (upl0 | upl1) begin
          width++;
        end else begin
          in_pulse = 1'b0;
          chk("pulse_width", width, PW);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=1 with nothing expected (cycle %0d)", cyc);
        end else begin
          chk("done_cycle", cyc, dq.pop_front());
        end
        chk("ready_at_done", int'(in_ready), 1);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a, a1, a2;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: {in_ready,busy,done,upl1,upl0} = 10000 for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_hold", int'({in_ready, busy, done, upl1, upl0}), 16);
    end

    send(15'b101010101010101, a);
    wait_idle();
    send(15'h0000, a);
    wait_idle();
    send(15'h7FFF, a);
    wait_idle();

    // Back-to-back: second offer waits through frame 1 and is accepted right after done.
    send(15'h1234, a1);
    send(15'h6DB6, a2);
    chk("b2b_accept", a2, a1 + NB * BP + 1);
    wait_idle();

    // Reset in the middle of a frame while a one-pulse is on the line.
    send(15'h0800, a);
    while (cyc < a + 50) @(negedge clk);
    chk("pre_reset_upl1", int'(upl1), 1);
    rst = 1'b1;
    #1;
    chk("reset_async_lines", int'({upl1, upl0}), 0);
    chk("reset_async_busy_done", int'({busy, done}), 0);
    chk("reset_async_ready", int'(in_ready), 1);
    pq.delete();
    dq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready), 1);
    send(15'h5A3C, a);
    wait_idle();

    // Keycode frame (or verbatim word in the default build).
    send(15'h0011, a);
    wait_idle();

    chk("pulse_queue_empty", pq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
